hazard_pipe_ctrl: RTL and testbench
===================================

# hazard_pipe_ctrl

Pipeline control block sitting between the hazard detection logic and the pipeline registers of the 5-stage RISC-V core. It tracks the destination register and write/load flags of each in-flight instruction through EX, MEM and WB; these are the `rd_*`/`reg_write_*`/`mem_read_ex` values the hazard logic consumes. It also acts on the returned `stall`/`forward` decisions: it freezes PC and IF/ID, inserts ID/EX bubbles, squashes on branch, holds the whole pipe on memory busy, and keeps saturating stall/flush counters.

## Interface
- `CNT_W`, default 16, width of the performance counters.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset. Asynchronous, active-low.
- `valid_id` in 1: ID stage holds a real instruction.
- `rd_id` in 5: destination register of the ID instruction.
- `reg_write_id` in 1: ID instruction writes the register file.
- `mem_read_id` in 1: ID instruction is a load.
- `forward_a_in`, `forward_b_in` in 2 each: operand select computed for the ID instruction.
- `stall_in` in 1: load-use stall request.
- `flush_in` in 1: branch/jump taken, resolved in EX.
- `mem_busy` in 1: data memory not ready; freeze the pipeline.
- `rd_ex`, `rd_mem`, `rd_wb` out 5: tracked destination registers.
- `reg_write_ex`, `reg_write_mem`, `reg_write_wb` out 1: tracked write flags.
- `mem_read_ex` out 1: EX instruction is a load.
- `forward_a_ex`, `forward_b_ex` out 2: selects latched with the instruction into ID/EX.
- `pc_write_en` out 1: PC may update this cycle.
- `ifid_write_en` out 1: IF/ID may load this cycle.
- `ifid_flush` out 1: IF/ID loads a NOP this cycle.
- `idex_bubble` out 1: ID/EX loads a NOP this cycle.
- `stall_cycles` out CNT_W: saturating count of stall cycles.
- `flush_count` out CNT_W: saturating count of flush events.

## Operation
- Effective stall: `st = stall_in & valid_id`. It is ignored when `valid_id`=0.
- Per-cycle mode is chosen by priority: FREEZE (`mem_busy`) > FLUSH (`flush_in`) > STALL (`st`) > RUN.
- **FREEZE**
  - All tracked registers and forward registers hold.
  - `pc_write_en`=0, `ifid_write_en`=0, `ifid_flush`=0, `idex_bubble`=0.
  - Counters hold.
  - A pending `flush_in` or `st` is not lost; it is re-evaluated in the next non-frozen cycle, because the upstream holds it.
- **FLUSH**
  - `pc_write_en`=1, `ifid_write_en`=1, `ifid_flush`=1, `idex_bubble`=1.
  - ID/EX slot becomes a bubble: `rd_ex`=0, `reg_write_ex`=0, `mem_read_ex`=0, `forward_*_ex`=00.
  - EX→MEM→WB advance.
  - `flush_count`+1.
  - A simultaneous `st` is discarded, since the ID instruction is wrong-path, and `stall_cycles` does not increment.
- **STALL**
  - `pc_write_en`=0, `ifid_write_en`=0, `idex_bubble`=1.
  - ID/EX loads a bubble; EX→MEM→WB advance.
  - `stall_cycles`+1.
- **RUN**
  - Enables = 1, `ifid_flush`=0, `idex_bubble`=0.
  - ID/EX loads `rd_id`, `reg_write_id & valid_id`, `mem_read_id & valid_id`, and `forward_*_in`, forced to 00 when `valid_id`=0.
  - EX→MEM→WB advance.
- WB stage register drops its contents on advance; there is no write-back retention.
- Counters saturate at all-ones and never wrap.
- All datapath and counters reset to 0 while `rst_n`=0, taking effect immediately regardless of `clk`.

## Timing
- `pc_write_en`, `ifid_write_en`, `ifid_flush` and `idex_bubble` are combinational from same-cycle inputs. They have no internal state dependency.
- Tracked fields, forward registers and counters update on the rising `clk` edge. Latency is 1 cycle per stage: ID info appears on `*_ex` 1 edge after acceptance, `*_mem` 2 edges, `*_wb` 3 edges.
- Reset values while `rst_n`=0:
  - All registered outputs are 0.
  - Combinational outputs evaluate normally from their inputs.
- Reset asserted mid-stall or mid-freeze clears all in-flight tracking. On the first edge after `rst_n` rises, the block is in RUN mode unless an input requests otherwise.
- A single load-use produces exactly one stall cycle: the bubble clears `mem_read_ex`, so the hazard logic drops `stall_in` next cycle.

## Test plan
- **RUN tracking:** present rd_id=5, reg_write_id=1, valid_id=1 for 1 cycle, then NOPs. Required: `rd_ex`=5 after edge 1, `rd_mem`=5 after edge 2, `rd_wb`=5 after edge 3, write flags following the same path, `rd_wb`=0 after edge 4.
- **Load-use stall:** load rd=7 (mem_read_id=1) then stall_in=1 for one cycle. Required that cycle: `pc_write_en`=0, `idex_bubble`=1. Next cycle: `rd_ex`=0, `rd_mem`=7, `stall_cycles`=1.
- **Flush beats stall:** flush_in=1 and stall_in=1 in the same cycle. Required: `ifid_flush`=1, `pc_write_en`=1, `flush_count`=1, `stall_cycles` unchanged, ID/EX a bubble.
- **Freeze:** mem_busy=1 for 3 cycles with rd_ex=3, rd_mem=4 and stall_in=1. Required: all tracked outputs hold at 3/4, enables are 0, counters unchanged. After release the stall is applied and `stall_cycles`+1.
- **Saturation:** with CNT_W=4, assert stall for 20 cycles. Required: `stall_cycles` sticks at 15.
- **Async reset:** drop `rst_n` mid-pipeline, between clock edges. Required: all registered outputs are 0 immediately, before the next `clk` edge.

Source files
------------

// File: rtl/hazard_pipe_ctrl.sv
// hazard_pipe_ctrl: tracks rd/write/load flags through EX/MEM/WB and drives stall, flush, freeze and perf counters.
module hazard_pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_id,
    input  logic [4:0]       rd_id,
    input  logic             reg_write_id,
    input  logic             mem_read_id,
    input  logic [1:0]       forward_a_in,
    input  logic [1:0]       forward_b_in,
    input  logic             stall_in,
    input  logic             flush_in,
    input  logic             mem_busy,
    output logic [4:0]       rd_ex,
    output logic [4:0]       rd_mem,
    output logic [4:0]       rd_wb,
    output logic             reg_write_ex,
    output logic             reg_write_mem,
    output logic             reg_write_wb,
    output logic             mem_read_ex,
    output logic [1:0]       forward_a_ex,
    output logic [1:0]       forward_b_ex,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    logic             flush_m, stall_m, run_m;
    logic [4:0]       rd_ex_q, rd_mem_q, rd_wb_q, rd_ex_d;
    logic             rw_ex_q, rw_mem_q, rw_wb_q, rw_ex_d;
    logic             mr_ex_q, mr_ex_d;
    logic [1:0]       fa_ex_q, fb_ex_q, fa_ex_d, fb_ex_d;
    logic [CNT_W-1:0] stall_q, flush_q, stall_d, flush_d;

    // Priority: freeze > flush > stall > run; a flush discards any stall
    assign flush_m = !mem_busy && flush_in;
    assign stall_m = !mem_busy && !flush_in && stall_in && valid_id;
    assign run_m   = !mem_busy && !flush_in && !stall_m;

    assign pc_write_en   = !mem_busy && !stall_m;
    assign ifid_write_en = !mem_busy && !stall_m;
    assign ifid_flush    = flush_m;
    assign idex_bubble   = flush_m || stall_m;

    always_comb begin
        rd_ex_d = run_m ? rd_id : 5'd0;
        rw_ex_d = run_m && reg_write_id && valid_id;
        mr_ex_d = run_m && mem_read_id && valid_id;
        fa_ex_d = (run_m && valid_id) ? forward_a_in : 2'b00;
        fb_ex_d = (run_m && valid_id) ? forward_b_in : 2'b00;
        stall_d = (stall_m && stall_q != '1) ? stall_q + 1'b1 : stall_q;
        flush_d = (flush_m && flush_q != '1) ? flush_q + 1'b1 : flush_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ex_q  <= '0;
            rd_mem_q <= '0;
            rd_wb_q  <= '0;
            rw_ex_q  <= 1'b0;
            rw_mem_q <= 1'b0;
            rw_wb_q  <= 1'b0;
            mr_ex_q  <= 1'b0;
            fa_ex_q  <= '0;
            fb_ex_q  <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else if (!mem_busy) begin
            rd_ex_q  <= rd_ex_d;
            rd_mem_q <= rd_ex_q;
            rd_wb_q  <= rd_mem_q;
            rw_ex_q  <= rw_ex_d;
            rw_mem_q <= rw_ex_q;
            rw_wb_q  <= rw_mem_q;
            mr_ex_q  <= mr_ex_d;
            fa_ex_q  <= fa_ex_d;
            fb_ex_q  <= fb_ex_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    assign rd_ex         = rd_ex_q;
    assign rd_mem        = rd_mem_q;
    assign rd_wb         = rd_wb_q;
    assign reg_write_ex  = rw_ex_q;
    assign reg_write_mem = rw_mem_q;
    assign reg_write_wb  = rw_wb_q;
    assign mem_read_ex   = mr_ex_q;
    assign forward_a_ex  = fa_ex_q;
    assign forward_b_ex  = fb_ex_q;
    assign stall_cycles  = stall_q;
    assign flush_count   = flush_q;
endmodule

// File: tb/tb_hazard_pipe_ctrl.sv
// tb_hazard_pipe_ctrl: directed checks of tracking, stall, flush, freeze, saturation and async reset.
module tb_hazard_pipe_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_id, reg_write_id, mem_read_id, stall_in, flush_in, mem_busy;
    logic [4:0] rd_id;
    logic [1:0] forward_a_in, forward_b_in;
    logic [4:0] rd_ex, rd_mem, rd_wb;
    logic       reg_write_ex, reg_write_mem, reg_write_wb, mem_read_ex;
    logic [1:0] forward_a_ex, forward_b_ex;
    logic       pc_write_en, ifid_write_en, ifid_flush, idex_bubble;
    logic [3:0] stall_cycles, flush_count;
    int         checks = 0;
    int         errors = 0;

    hazard_pipe_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .valid_id(valid_id), .rd_id(rd_id),
        .reg_write_id(reg_write_id), .mem_read_id(mem_read_id),
        .forward_a_in(forward_a_in), .forward_b_in(forward_b_in),
        .stall_in(stall_in), .flush_in(flush_in), .mem_busy(mem_busy),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .reg_write_ex(reg_write_ex), .reg_write_mem(reg_write_mem), .reg_write_wb(reg_write_wb),
        .mem_read_ex(mem_read_ex), .forward_a_ex(forward_a_ex), .forward_b_ex(forward_b_ex),
        .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
        .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                         input logic [1:0] fa, input logic [1:0] fb,
                         input logic st, input logic fl, input logic mb);
        valid_id = v; rd_id = rd; reg_write_id = rw; mem_read_id = mr;
        forward_a_in = fa; forward_b_in = fb; stall_in = st; flush_in = fl; mem_busy = mb;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_rd_ex", rd_ex, 0);
        chk("rst_rw_wb", reg_write_wb, 0);
        chk("rst_stall_cnt", stall_cycles, 0);
        chk("rst_pc_we_comb", pc_write_en, 1);
        @(negedge clk);
        rst_n = 1'b1;
        // RUN tracking
        drive(1, 5, 1, 0, 2, 1, 0, 0, 0);
        @(negedge clk);
        chk("run_rd_ex", rd_ex, 5);
        chk("run_rw_ex", reg_write_ex, 1);
        chk("run_fa_ex", forward_a_ex, 2);
        chk("run_fb_ex", forward_b_ex, 1);
        drive(0, 0, 0, 0, 3, 3, 1, 0, 0);
        #1;
        chk("invalid_stall_pc_we", pc_write_en, 1);
        chk("invalid_stall_bubble", idex_bubble, 0);
        @(negedge clk);
        chk("run_rd_mem", rd_mem, 5);
        chk("run_rw_mem", reg_write_mem, 1);
        chk("run_rd_ex_nop", rd_ex, 0);
        chk("nop_fa_forced", forward_a_ex, 0);
        chk("invalid_stall_cnt", stall_cycles, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("run_rd_wb", rd_wb, 5);
        chk("run_rw_wb", reg_write_wb, 1);
        @(negedge clk);
        chk("run_rd_wb_drop", rd_wb, 0);
        chk("run_rw_wb_drop", reg_write_wb, 0);
        // Load-use stall
        drive(1, 7, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("load_mr_ex", mem_read_ex, 1);
        drive(1, 8, 1, 0, 0, 0, 1, 0, 0);
        #1;
        chk("stall_pc_we", pc_write_en, 0);
        chk("stall_ifid_we", ifid_write_en, 0);
        chk("stall_bubble", idex_bubble, 1);
        chk("stall_ifid_flush", ifid_flush, 0);
        @(negedge clk);
        chk("stall_rd_ex", rd_ex, 0);
        chk("stall_mr_ex", mem_read_ex, 0);
        chk("stall_rd_mem", rd_mem, 7);
        chk("stall_cnt1", stall_cycles, 1);
        drive(1, 8, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("after_stall_rd_ex", rd_ex, 8);
        chk("after_stall_rd_wb", rd_wb, 7);
        // Flush beats stall
        drive(1, 9, 1, 0, 1, 1, 1, 1, 0);
        #1;
        chk("flush_ifid_flush", ifid_flush, 1);
        chk("flush_pc_we", pc_write_en, 1);
        chk("flush_ifid_we", ifid_write_en, 1);
        chk("flush_bubble", idex_bubble, 1);
        @(negedge clk);
        chk("flush_cnt", flush_count, 1);
        chk("flush_stall_cnt", stall_cycles, 1);
        chk("flush_rd_ex", rd_ex, 0);
        chk("flush_rw_ex", reg_write_ex, 0);
        chk("flush_fa_ex", forward_a_ex, 0);
        chk("flush_rd_mem", rd_mem, 8);
        // Freeze with pending stall
        drive(1, 4, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("pre_freeze_rd_ex", rd_ex, 3);
        chk("pre_freeze_rd_mem", rd_mem, 4);
        drive(1, 6, 1, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("freeze_pc_we", pc_write_en, 0);
            chk("freeze_ifid_we", ifid_write_en, 0);
            chk("freeze_bubble", idex_bubble, 0);
            @(negedge clk);
            chk("freeze_rd_ex", rd_ex, 3);
            chk("freeze_rd_mem", rd_mem, 4);
            chk("freeze_stall_cnt", stall_cycles, 1);
            chk("freeze_flush_cnt", flush_count, 1);
        end
        mem_busy = 1'b0;
        #1;
        chk("unfreeze_bubble", idex_bubble, 1);
        chk("unfreeze_pc_we", pc_write_en, 0);
        @(negedge clk);
        chk("unfreeze_stall_cnt", stall_cycles, 2);
        chk("unfreeze_rd_ex", rd_ex, 0);
        chk("unfreeze_rd_mem", rd_mem, 3);
        chk("unfreeze_rd_wb", rd_wb, 4);
        // Saturation: 2 + 13 stall cycles reaches 15, then sticks
        for (int i = 0; i < 13; i++) @(negedge clk);
        chk("sat_reach", stall_cycles, 15);
        for (int i = 0; i < 7; i++) @(negedge clk);
        chk("sat_stick", stall_cycles, 15);
        // Async reset mid-pipeline
        drive(1, 5, 1, 1, 1, 2, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_rd_mem", rd_mem, 5);
        chk("pre_rst_mr_ex", mem_read_ex, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rd_ex", rd_ex, 0);
        chk("arst_rd_mem", rd_mem, 0);
        chk("arst_rw_mem", reg_write_mem, 0);
        chk("arst_mr_ex", mem_read_ex, 0);
        chk("arst_fb_ex", forward_b_ex, 0);
        chk("arst_stall_cnt", stall_cycles, 0);
        chk("arst_flush_cnt", flush_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 10, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("post_rst_rd_ex", rd_ex, 10);
        chk("post_rst_rd_mem", rd_mem, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
